// File: rtl/ru_sched_pkg.sv
// rtl/ru_sched_pkg.sv - shared types and constants for the register-file write scheduler
package ru_sched_pkg;

  typedef enum logic {S_INIT, S_RUN} ru_state_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_INIT, GNT_CPU, GNT_DBG} ru_gnt_t;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_SP = 5'd2;

endpackage

// File: rtl/ru_init_sweep.sv
// rtl/ru_init_sweep.sv - walks x1..x(NREGS-1) once, supplying the address/data to clear the register file
module ru_init_sweep
  import ru_sched_pkg::*;
#(
  parameter int          XLEN    = 32,
  parameter int          NREGS   = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
  parameter int          PW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active_i,
  input  logic            clr_i,
  output logic [PW-1:0]   rd_o,
  output logic [XLEN-1:0] data_o,
  output logic            last_o,
  output logic            done_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          done_q, done_d;

  assign rd_o   = ptr_q;
  assign data_o = (ptr_q == PW'(REG_SP)) ? XLEN'(SP_INIT) : '0;
  assign last_o = (ptr_q == PW'(NREGS - 1));
  assign done_o = done_q;

  always_comb begin
    ptr_d  = ptr_q;
    done_d = done_q;
    if (clr_i) begin
      ptr_d  = PW'(1);
      done_d = 1'b0;
    end else if (active_i) begin
      // Wrap back to x1 so a later restart starts from a known pointer.
      ptr_d = last_o ? PW'(1) : ptr_q + 1'b1;
      if (last_o) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= PW'(1);
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/ru_write_scheduler.sv
// rtl/ru_write_scheduler.sv - owns the register-file write port: init sweep, then core/debug arbitration
module ru_write_scheduler
  import ru_sched_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter logic [31:0] SP_INIT    = 32'h0000_0FFC,
  parameter int          STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_we,
  input  logic [4:0]      cpu_rd,
  input  logic [XLEN-1:0] cpu_data,
  input  logic            dbg_valid,
  input  logic [4:0]      dbg_rd,
  input  logic [XLEN-1:0] dbg_data,
  output logic            dbg_ready,
  input  logic            clr_req,
  output logic            RUWr,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] DataWr,
  output logic            stall_core,
  output logic            init_done
);

  localparam int PW = $clog2(NREGS);
  localparam int SW = $clog2(STARVE_MAX + 1);

  ru_state_t       state_q;
  logic [SW-1:0]   starve_cnt_q;
  ru_gnt_t         gnt;
  logic            dbg_forced;
  logic            cpu_eff;
  logic [PW-1:0]   sweep_rd;
  logic [XLEN-1:0] sweep_data;
  logic            sweep_last;

  ru_init_sweep #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_INIT (SP_INIT),
    .PW      (PW)
  ) u_sweep (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q == S_INIT),
    .clr_i    (clr_req),
    .rd_o     (sweep_rd),
    .data_o   (sweep_data),
    .last_o   (sweep_last),
    .done_o   (init_done)
  );

  assign cpu_eff    = cpu_we && (cpu_rd != REG_X0);
  assign dbg_forced = dbg_valid && (starve_cnt_q == SW'(STARVE_MAX));

  // rst gates the grant directly so the port goes quiet the instant reset is raised.
  always_comb begin
    gnt = GNT_NONE;
    if (rst)                    gnt = GNT_NONE;
    else if (state_q == S_INIT) gnt = GNT_INIT;
    else if (dbg_forced)        gnt = GNT_DBG;
    else if (cpu_eff)           gnt = GNT_CPU;
    else if (dbg_valid)         gnt = GNT_DBG;
  end

  always_comb begin
    RUWr       = 1'b0;
    rd         = REG_X0;
    DataWr     = '0;
    dbg_ready  = 1'b0;
    stall_core = rst;
    case (gnt)
      GNT_INIT: begin
        RUWr       = 1'b1;
        rd         = 5'(sweep_rd);
        DataWr     = sweep_data;
        stall_core = 1'b1;
      end
      GNT_CPU: begin
        RUWr   = 1'b1;
        rd     = cpu_rd;
        DataWr = cpu_data;
      end
      GNT_DBG: begin
        // A debug write to x0 is still handshaken, just never reaches the file.
        RUWr       = (dbg_rd != REG_X0);
        rd         = dbg_rd;
        DataWr     = dbg_data;
        dbg_ready  = 1'b1;
        stall_core = dbg_forced;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      starve_cnt_q <= '0;
    end else if (clr_req) begin
      state_q      <= S_INIT;
      starve_cnt_q <= '0;
    end else begin
      if (state_q == S_INIT && sweep_last) state_q <= S_RUN;
      if (state_q == S_RUN) begin
        if (gnt == GNT_DBG || !dbg_valid)
          starve_cnt_q <= '0;
        else if (gnt == GNT_CPU && starve_cnt_q != SW'(STARVE_MAX))
          starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ru_write_scheduler.sv
// tb/tb_ru_write_scheduler.sv - directed bench with a write scoreboard and a register-file model
module tb_ru_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_data;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        clr_req;
  logic        RUWr;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic        stall_core;
  logic        init_done;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] regs[32];
  int          total  = 0;
  int          passed = 0;
  int          fails  = 0;

  ru_write_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_we     (cpu_we),
    .cpu_rd     (cpu_rd),
    .cpu_data   (cpu_data),
    .dbg_valid  (dbg_valid),
    .dbg_rd     (dbg_rd),
    .dbg_data   (dbg_data),
    .dbg_ready  (dbg_ready),
    .clr_req    (clr_req),
    .RUWr       (RUWr),
    .rd         (rd),
    .DataWr     (DataWr),
    .stall_core (stall_core),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  // RegisterUnit stand-in: x0 is hardwired to zero on read.
  always @(posedge clk) if (RUWr) regs[rd] <= DataWr;

  function automatic logic [31:0] rf_read(input int idx);
    return (idx == 0) ? 32'h0 : regs[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t w;
    w.rd   = r;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_sweep();
    for (int i = 1; i < 32; i++) push_wr(5'(i), (i == 2) ? 32'h0000_0FFC : 32'h0);
  endtask

  // Samples at negedge; every observed write must match the oldest expected one.
  task automatic sample();
    wr_t w;
    @(negedge clk);
    if (RUWr) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write_rd", {27'b0, rd}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("sb_rd", {27'b0, rd}, {27'b0, w.rd});
        chk("sb_data", DataWr, w.data);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hBAD0_0000 | i;
    rst = 1'b1; cpu_we = 0; cpu_rd = 0; cpu_data = 0;
    dbg_valid = 0; dbg_rd = 0; dbg_data = 0; clr_req = 0;

    // Reset state
    sample();
    chk("rst_RUWr", {31'b0, RUWr}, 32'd0);
    chk("rst_rd", {27'b0, rd}, 32'd0);
    chk("rst_DataWr", DataWr, 32'd0);
    chk("rst_stall", {31'b0, stall_core}, 32'd1);
    chk("rst_dbg_ready", {31'b0, dbg_ready}, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    adv();
    rst = 1'b0;

    // 1. Init sweep
    push_sweep();
    sample();
    chk("sweep_stall", {31'b0, stall_core}, 32'd1);
    adv();
    run_cycles(29);
    sample();
    chk("init_done_before_last", {31'b0, init_done}, 32'd0);
    adv();
    chk("init_done_after", {31'b0, init_done}, 32'd1);
    chk("sweep_drained", exp_q.size(), 32'd0);
    chk("x2_sp", rf_read(2), 32'h0000_0FFC);
    chk("x5_zero", rf_read(5), 32'h0);
    chk("x31_zero", rf_read(31), 32'h0);
    sample();
    chk("run_idle_RUWr", {31'b0, RUWr}, 32'd0);
    adv();

    // 2. Core write, zero latency
    cpu_we = 1; cpu_rd = 5; cpu_data = 32'hA5A5_A5A5;
    push_wr(5, 32'hA5A5_A5A5);
    sample();
    chk("cpu_stall", {31'b0, stall_core}, 32'd0);
    chk("cpu_dbg_ready", {31'b0, dbg_ready}, 32'd0);
    adv();
    cpu_we = 0;
    chk("x5_cpu", rf_read(5), 32'hA5A5_A5A5);

    // 3. Core write to x0 yields to debug
    cpu_we = 1; cpu_rd = 0; cpu_data = 32'hABCD_1234;
    dbg_valid = 1; dbg_rd = 10; dbg_data = 32'hDEAD_BEEF;
    push_wr(10, 32'hDEAD_BEEF);
    sample();
    chk("x0cpu_dbg_ready", {31'b0, dbg_ready}, 32'd1);
    chk("x0cpu_stall", {31'b0, stall_core}, 32'd0);
    adv();
    cpu_we = 0; dbg_valid = 0;
    chk("x10_dbg", rf_read(10), 32'hDEAD_BEEF);
    chk("x0_zero", rf_read(0), 32'h0);

    // Debug write to x0: accepted, discarded
    dbg_valid = 1; dbg_rd = 0; dbg_data = 32'hFFFF_FFFF;
    sample();
    chk("dbg_x0_ready", {31'b0, dbg_ready}, 32'd1);
    chk("dbg_x0_RUWr", {31'b0, RUWr}, 32'd0);
    adv();
    dbg_valid = 0;

    // 4. Starvation guard
    dbg_valid = 1; dbg_rd = 7; dbg_data = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      cpu_we = 1; cpu_rd = 5'(3 + k); cpu_data = 32'hC000_0000 | k;
      push_wr(5'(3 + k), 32'hC000_0000 | k);
      sample();
      chk("starve_core_wins", {31'b0, dbg_ready}, 32'd0);
      adv();
    end
    cpu_rd = 20; cpu_data = 32'h2020_2020;
    push_wr(7, 32'h1234_5678);
    sample();
    chk("forced_dbg_ready", {31'b0, dbg_ready}, 32'd1);
    chk("forced_stall", {31'b0, stall_core}, 32'd1);
    chk("forced_rd", {27'b0, rd}, 32'd7);
    adv();
    dbg_valid = 0;
    chk("x7_dbg", rf_read(7), 32'h1234_5678);
    chk("starve_cleared", 32'(dut.starve_cnt_q), 32'd0);
    push_wr(20, 32'h2020_2020);
    sample();
    chk("replay_stall", {31'b0, stall_core}, 32'd0);
    adv();
    chk("x20_replay", rf_read(20), 32'h2020_2020);

    // 5. clr_req restarts the sweep; the current grant still completes
    cpu_rd = 5; cpu_data = 32'h0000_0055;
    push_wr(5, 32'h0000_0055);
    run_cycles(1);
    cpu_rd = 6; cpu_data = 32'h0000_0066; clr_req = 1;
    push_wr(6, 32'h0000_0066);
    run_cycles(1);
    cpu_we = 0; clr_req = 0;
    chk("clr_init_done", {31'b0, init_done}, 32'd0);
    chk("x6_before_sweep", rf_read(6), 32'h0000_0066);
    push_sweep();
    run_cycles(31);
    chk("clr_sweep_done", {31'b0, init_done}, 32'd1);
    chk("clr_drained", exp_q.size(), 32'd0);
    chk("x5_cleared", rf_read(5), 32'h0);

    // 6. rst mid-sweep
    clr_req = 1;
    run_cycles(1);
    clr_req = 0;
    for (int i = 1; i < 15; i++) push_wr(5'(i), (i == 2) ? 32'h0000_0FFC : 32'h0);
    run_cycles(14);
    rst = 1;
    sample();
    chk("midrst_RUWr", {31'b0, RUWr}, 32'd0);
    chk("midrst_rd", {27'b0, rd}, 32'd0);
    adv();
    adv();
    rst = 0;
    push_sweep();
    sample();
    chk("restart_rd1", {27'b0, rd}, 32'd1);
    adv();
    run_cycles(30);
    chk("final_init_done", {31'b0, init_done}, 32'd1);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
